// File: rtl/vector_reg_file.sv
// rtl/vector_reg_file.sv - lane-masked SIMD register file with per-register pending scoreboard
// Optional same-cycle write-to-read forwarding is enabled by defining VRF_BYPASS_EN.
module vector_reg_file #(
  parameter int LANES    = 16,
  parameter int LANE_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          rSel1,
  input  logic [SEL_W-1:0]          rSel2,
  output logic [LANES*LANE_W-1:0]   operand1,
  output logic [LANES*LANE_W-1:0]   operand2,
  output logic                      hazard1,
  output logic                      hazard2,
  input  logic                      allocValid,
  input  logic [SEL_W-1:0]          allocReg,
  output logic                      allocReady,
  input  logic                      wrEn,
  input  logic [SEL_W-1:0]          regToWrite,
  input  logic [LANES-1:0]          laneMask,
  input  logic [LANES*LANE_W-1:0]   dataIn,
  output logic [NUM_REGS-1:0]       pendingVec
);

  localparam int REG_W = LANES * LANE_W;

  logic [REG_W-1:0]    regs_q [NUM_REGS];
  logic [REG_W-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  logic [SEL_W-1:0]    rsel  [2];
  logic [REG_W-1:0]    rdata [2];
  logic [1:0]          rhaz;

  assign rsel[0]    = rSel1;
  assign rsel[1]    = rSel2;
  assign operand1   = rdata[0];
  assign operand2   = rdata[1];
  assign hazard1    = rhaz[0];
  assign hazard2    = rhaz[1];
  assign pendingVec = pending_q;

  // Out-of-range allocation targets match no register, so they are silently dropped.
  always_comb begin
    allocReady = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (allocReg == SEL_W'(r)) allocReady = ~pending_q[r];
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (wrEn && (regToWrite == SEL_W'(r))) begin
        pending_d[r] = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          if (laneMask[l]) regs_d[r][l*LANE_W +: LANE_W] = dataIn[l*LANE_W +: LANE_W];
        end
      end
      // A new producer takes ownership even if the old one retires this cycle.
      if (allocValid && allocReady && (allocReg == SEL_W'(r))) pending_d[r] = 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rhaz[p]  = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rsel[p] == SEL_W'(r)) begin
          rdata[p] = regs_q[r];
          rhaz[p]  = pending_q[r];
        end
      end
`ifdef VRF_BYPASS_EN
      if (wrEn && (rsel[p] == regToWrite) && (int'(regToWrite) < NUM_REGS)) begin
        for (int l = 0; l < LANES; l++) begin
          if (laneMask[l]) rdata[p][l*LANE_W +: LANE_W] = dataIn[l*LANE_W +: LANE_W];
        end
        if (&laneMask) rhaz[p] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

endmodule

// File: tb/tb_vector_reg_file.sv
// tb/tb_vector_reg_file.sv - directed scoreboard bench for vector_reg_file
module tb_vector_reg_file;

  logic         clk;
  logic         reset;
  logic [2:0]   rSel1, rSel2, allocReg, regToWrite;
  logic [127:0] operand1, operand2, dataIn;
  logic         hazard1, hazard2, allocValid, allocReady, wrEn;
  logic [15:0]  laneMask;
  logic [7:0]   pendingVec;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] SEQ_D = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] ALL_AA = {16{8'hAA}};
  localparam logic [127:0] ALL_55 = {16{8'h55}};
  localparam logic [127:0] X_DAT = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] R4_OLD = 128'h11112222_33334444_55556666_77778888;

  vector_reg_file dut (
    .clk(clk), .reset(reset),
    .rSel1(rSel1), .rSel2(rSel2),
    .operand1(operand1), .operand2(operand2),
    .hazard1(hazard1), .hazard2(hazard2),
    .allocValid(allocValid), .allocReg(allocReg), .allocReady(allocReady),
    .wrEn(wrEn), .regToWrite(regToWrite), .laneMask(laneMask), .dataIn(dataIn),
    .pendingVec(pendingVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [127:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] exp_v;
    reset = 1'b0; rSel1 = '0; rSel2 = '0; allocValid = 1'b0; allocReg = '0;
    wrEn = 1'b0; regToWrite = '0; laneMask = '0; dataIn = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rSel2 = 3'd7;
    #1;
    expect_val("reset_pending", 128'd0);    check(pendingVec);
    expect_val("reset_allocReady", 128'd1); check(allocReady);
    expect_val("reset_hazards", 128'd0);    check({hazard1, hazard2});
    for (int r = 0; r < 8; r++) begin
      rSel1 = 3'(r);
      #1;
      expect_val($sformatf("reset_read_r%0d", r), 128'd0);
      check(operand1);
    end

    // Full write / read, including identical selects
    tick();
    wrEn = 1'b1; regToWrite = 3'd3; laneMask = 16'hFFFF; dataIn = SEQ_D;
    expect_val("full_write_op1", SEQ_D);
    expect_val("full_write_op2_r0", 128'd0);
    expect_val("write_nonpending_pending", 128'd0);
    tick();
    wrEn = 1'b0; rSel1 = 3'd3; rSel2 = 3'd0;
    #1;
    check(operand1); check(operand2); check(pendingVec);
    rSel2 = 3'd3;
    #1;
    expect_val("same_sel_op2", SEQ_D); check(operand2);

    // Lane mask
    wrEn = 1'b1; regToWrite = 3'd5; laneMask = 16'hFFFF; dataIn = ALL_AA;
    tick();
    laneMask = 16'h00F0; dataIn = ALL_55;
    exp_v = ALL_AA;
    for (int l = 4; l < 8; l++) exp_v[l*8 +: 8] = 8'h55;
    expect_val("lane_mask_r5", exp_v);
    tick();
    wrEn = 1'b0; rSel1 = 3'd5;
    #1;
    check(operand1);

    // Scoreboard
    allocValid = 1'b1; allocReg = 3'd2; rSel1 = 3'd2;
    #1;
    expect_val("alloc_ready_free", 128'd1); check(allocReady);
    tick();
    allocValid = 1'b0;
    #1;
    expect_val("alloc_pending", 128'h04); check(pendingVec);
    expect_val("alloc_hazard1", 128'd1);  check(hazard1);
    allocValid = 1'b1;
    #1;
    expect_val("realloc_ready", 128'd0);  check(allocReady);
    tick();
    allocValid = 1'b0;
    expect_val("realloc_pending_held", 128'h04); check(pendingVec);
    wrEn = 1'b1; regToWrite = 3'd2; laneMask = 16'h0000; dataIn = ALL_55;
    tick();
    wrEn = 1'b0;
    #1;
    expect_val("wb_clear_pending", 128'd0); check(pendingVec);
    expect_val("zero_mask_data", 128'd0);   check(operand1);
    allocValid = 1'b1; allocReg = 3'd2;
    wrEn = 1'b1; regToWrite = 3'd2; laneMask = 16'hFFFF; dataIn = 128'h1234;
    tick();
    allocValid = 1'b0; wrEn = 1'b0;
    #1;
    expect_val("alloc_wb_same_cycle", 128'h04); check(pendingVec);
    expect_val("alloc_wb_data", 128'h1234);     check(operand1);
    wrEn = 1'b1; regToWrite = 3'd2; laneMask = 16'h0000;
    tick();
    wrEn = 1'b0;

    // Bypass
    wrEn = 1'b1; regToWrite = 3'd4; laneMask = 16'hFFFF; dataIn = R4_OLD;
    allocValid = 1'b1; allocReg = 3'd4;
    tick();
    wrEn = 1'b0; allocValid = 1'b0; rSel1 = 3'd4;
    #1;
    expect_val("bypass_setup_pending", 128'h10); check(pendingVec);
    wrEn = 1'b1; regToWrite = 3'd4; laneMask = 16'h0001; dataIn = X_DAT;
    #1;
`ifdef VRF_BYPASS_EN
    exp_v = {R4_OLD[127:8], X_DAT[7:0]};
`else
    exp_v = R4_OLD;
`endif
    expect_val("partial_bypass_op1", exp_v); check(operand1);
    expect_val("partial_bypass_hz1", 128'd1); check(hazard1);
    laneMask = 16'hFFFF;
    #1;
`ifdef VRF_BYPASS_EN
    expect_val("bypass_op1", X_DAT);  expect_val("bypass_hz1", 128'd0);
`else
    expect_val("bypass_op1", R4_OLD); expect_val("bypass_hz1", 128'd1);
`endif
    check(operand1); check(hazard1);
    tick();
    wrEn = 1'b0;
    #1;
    expect_val("post_write_op1", X_DAT); check(operand1);
    expect_val("post_write_hz1", 128'd0); check(hazard1);

    // Async reset mid-operation
    allocValid = 1'b1; allocReg = 3'd1;
    tick();
    allocReg = 3'd6;
    wrEn = 1'b1; regToWrite = 3'd6; laneMask = 16'hFFFF; dataIn = SEQ_D;
    tick();
    allocValid = 1'b0; wrEn = 1'b0; rSel1 = 3'd6; rSel2 = 3'd3;
    #1;
    expect_val("pre_reset_pending", 128'h42); check(pendingVec);
    expect_val("pre_reset_op1", SEQ_D);       check(operand1);
    #1 reset = 1'b0;
    #1;
    expect_val("async_reset_pending", 128'd0); check(pendingVec);
    expect_val("async_reset_op1", 128'd0);     check(operand1);
    expect_val("async_reset_op2", 128'd0);     check(operand2);
    expect_val("async_reset_hz1", 128'd0);     check(hazard1);
    expect_val("async_reset_ready", 128'd1);   check(allocReady);
    tick();
    reset = 1'b1;
    #1;
    expect_val("after_reset_op2", 128'd0); check(operand2);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
